// File: rtl/sweep_gen_pkg.sv
// Shared types and derived-width helpers for the sweep signal generator.
// Widths depend on the parameters, so they are exposed as constant functions.
package sweep_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_e;

    // Never returns 0, so a degenerate size still yields a legal vector width.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned image_words(input int unsigned num_ch,
                                                input int unsigned depth,
                                                input int unsigned word_w);
        return (num_ch * depth) / word_w;
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned num_ch,
                                          input int unsigned depth,
                                          input int unsigned word_w);
        return clog2_min1(image_words(num_ch, depth, word_w));
    endfunction

    function automatic bit params_legal(input int unsigned num_ch,
                                        input int unsigned depth,
                                        input int unsigned word_w);
        return (num_ch >= 1) && (num_ch <= 16) &&
               (word_w >= 8) && (word_w <= 64) &&
               (depth >= word_w) && ((depth % word_w) == 0);
    endfunction

endpackage

// File: rtl/sweep_bank_loader.sv
// Load-stream front end: handshake, shadow-bank write pointer, image
// length checking and the shadow_full flag.
module sweep_bank_loader
    import sweep_gen_pkg::*;
#(
    parameter int unsigned IMAGE_WORDS = 4,
    parameter int unsigned PTR_W       = clog2_min1(IMAGE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld_valid,
    input  logic             ld_last,
    input  logic             swap,
    output logic             ld_ready,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             shadow_full,
    output logic             ld_err
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IMAGE_WORDS - 1);

    logic can_accept;
    logic final_word;

    assign can_accept = en && !shadow_full;
    assign wr_en      = ld_valid && can_accept;
    assign final_word = (wr_ptr == LAST_PTR);
    // Reset gating is kept off the internal accept path so it never reaches flop data inputs.
    assign ld_ready   = can_accept && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            shadow_full <= 1'b0;
            ld_err      <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            if (swap) begin
                shadow_full <= 1'b0;
            end
            if (!en) begin
                wr_ptr <= '0;
            end else if (wr_en) begin
                if (ld_last && final_word) begin
                    shadow_full <= 1'b1;
                    wr_ptr      <= '0;
                end else if (ld_last || final_word) begin
                    ld_err <= 1'b1;
                    wr_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sweep_signal_generator.sv
// Double-buffered per-channel bit-pattern sweep generator: the shadow bank is
// loaded over a stream while the active bank is replayed one bin per CLK_PE.
module sweep_signal_generator
    import sweep_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 3200,
    parameter int unsigned WORD_W = 32
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST_N,
    input  logic              EN,
    input  logic              TRIG,
    input  logic              CLK_PE,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [WORD_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic [NUM_CH-1:0] GEN_SIGNAL,
    output logic              BUSY,
    output logic              STALE,
    output logic              LD_ERR
);

    localparam int unsigned IMAGE_WORDS = image_words(NUM_CH, DEPTH, WORD_W);
    localparam int unsigned PTR_W       = ptr_w(NUM_CH, DEPTH, WORD_W);
    localparam int unsigned IDX_W       = idx_w(DEPTH);
    localparam int unsigned BIT_W       = clog2_min1(WORD_W);
    localparam int unsigned WPC         = DEPTH / WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    if (!params_legal(NUM_CH, DEPTH, WORD_W)) begin : g_param_check
        $error("sweep_signal_generator: illegal NUM_CH/DEPTH/WORD_W combination");
    end

    sweep_state_e     state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             active_b;
    logic             stale_q;
    logic             trig_acc;
    logic             swap;
    logic             shadow_full;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;

    logic [WORD_W-1:0] mem_a [IMAGE_WORDS];
    logic [WORD_W-1:0] mem_b [IMAGE_WORDS];

    assign trig_acc = EN && TRIG;
    // shadow_full is sampled pre-edge, so a load finishing on the TRIG cycle is not swapped in.
    assign swap     = trig_acc && shadow_full;

    sweep_bank_loader #(
        .IMAGE_WORDS (IMAGE_WORDS),
        .PTR_W       (PTR_W)
    ) u_loader (
        .clk         (SYS_CLK),
        .rst_n       (SYS_RST_N),
        .en          (EN),
        .ld_valid    (LD_VALID),
        .ld_last     (LD_LAST),
        .swap        (swap),
        .ld_ready    (LD_READY),
        .wr_en       (wr_en),
        .wr_ptr      (wr_ptr),
        .shadow_full (shadow_full),
        .ld_err      (LD_ERR)
    );

    always_ff @(posedge SYS_CLK) begin
        if (wr_en) begin
            if (active_b) begin
                mem_a[wr_ptr] <= LD_DATA;
            end else begin
                mem_b[wr_ptr] <= LD_DATA;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state    <= ST_IDLE;
            idx      <= '0;
            active_b <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            stale_q <= trig_acc && !shadow_full;
            if (swap) begin
                active_b <= !active_b;
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (!EN) begin
            state_n = ST_IDLE;
            idx_n   = '0;
        end else if (TRIG) begin
            state_n = ST_RUN;
            idx_n   = '0;
        end else if (state == ST_RUN && CLK_PE) begin
            if (idx == LAST_IDX) begin
                state_n = ST_DONE;
                idx_n   = '0;
            end else begin
                idx_n = idx + 1'b1;
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0]  word_addr;
        logic [BIT_W-1:0]  bit_sel;
        logic [WORD_W-1:0] rd_word;
        int unsigned       bin;
        GEN_SIGNAL = '0;
        word_addr  = '0;
        bit_sel    = '0;
        rd_word    = '0;
        bin        = 32'(idx);
        BUSY       = (state == ST_RUN);
        STALE      = stale_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            word_addr     = PTR_W'(c * WPC + bin / WORD_W);
            bit_sel       = BIT_W'(bin % WORD_W);
            rd_word       = active_b ? mem_b[word_addr] : mem_a[word_addr];
            GEN_SIGNAL[c] = rd_word[bit_sel] && BUSY && EN;
        end
    end

endmodule

// File: tb/tb_sweep_signal_generator.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// a randomized run, all checked against a bank/sweep reference model.
module tb_sweep_signal_generator;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 64;
    localparam int WORD_W = 32;
    localparam int IMG    = NUM_CH * DEPTH / WORD_W;
    localparam int NBITS  = NUM_CH * DEPTH;

    logic              SYS_CLK   = 1'b0;
    logic              SYS_RST_N = 1'b0;
    logic              EN        = 1'b0;
    logic              TRIG      = 1'b0;
    logic              CLK_PE    = 1'b0;
    logic              LD_VALID  = 1'b0;
    logic              LD_LAST   = 1'b0;
    logic [WORD_W-1:0] LD_DATA   = '0;
    logic              LD_READY;
    logic [NUM_CH-1:0] GEN_SIGNAL;
    logic              BUSY;
    logic              STALE;
    logic              LD_ERR;

    sweep_signal_generator #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .SYS_RST_N  (SYS_RST_N),
        .EN         (EN),
        .TRIG       (TRIG),
        .CLK_PE     (CLK_PE),
        .LD_VALID   (LD_VALID),
        .LD_READY   (LD_READY),
        .LD_DATA    (LD_DATA),
        .LD_LAST    (LD_LAST),
        .GEN_SIGNAL (GEN_SIGNAL),
        .BUSY       (BUSY),
        .STALE      (STALE),
        .LD_ERR     (LD_ERR)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: two flat bit images (channel-major, bin within channel).
    bit img   [2][NBITS];
    bit known [2][NBITS];
    bit m_run;
    int m_bin;
    int m_act;
    bit m_full;
    int m_cnt;
    bit m_stale;
    bit m_err;

    typedef struct {
        logic              en;
        logic              trig;
        logic              pe;
        logic              vld;
        logic [WORD_W-1:0] data;
        logic              last;
        logic [NUM_CH-1:0] gen;
        logic              busy;
        logic              stale;
        logic              err;
        logic              rdy;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_bin   = 0;
        m_act   = 0;
        m_full  = 1'b0;
        m_cnt   = 0;
        m_stale = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        bit full_pre;
        int sh;
        full_pre = m_full;
        sh       = 1 - m_act;
        m_stale  = 1'b0;
        m_err    = 1'b0;
        if (!EN) begin
            m_run = 1'b0;
            m_bin = 0;
            m_cnt = 0;
        end else begin
            if (LD_VALID && !full_pre) begin
                for (int b = 0; b < WORD_W; b++) begin
                    img[sh][m_cnt * WORD_W + b]   = LD_DATA[b];
                    known[sh][m_cnt * WORD_W + b] = 1'b1;
                end
                if (m_cnt == IMG - 1 && LD_LAST) begin
                    m_full = 1'b1;
                    m_cnt  = 0;
                end else if (LD_LAST || m_cnt == IMG - 1) begin
                    m_err = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (TRIG) begin
                m_stale = !full_pre;
                if (full_pre) begin
                    m_act  = 1 - m_act;
                    m_full = 1'b0;
                end
                m_run = 1'b1;
                m_bin = 0;
            end else if (m_run && CLK_PE) begin
                if (m_bin == DEPTH - 1) begin
                    m_run = 1'b0;
                    m_bin = 0;
                end else begin
                    m_bin++;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NUM_CH-1:0] exp_gen;
        bit                ok;
        exp_gen = '0;
        ok      = 1'b1;
        check("busy", BUSY, m_run);
        check("stale", STALE, m_stale);
        check("ld_err", LD_ERR, m_err);
        check("ld_ready", LD_READY, EN && !m_full);
        if (m_run && EN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!known[m_act][c * DEPTH + m_bin]) ok = 1'b0;
                exp_gen[c] = img[m_act][c * DEPTH + m_bin];
            end
        end
        if (ok) check("gen", GEN_SIGNAL, exp_gen);
    endtask

    task automatic step();
        @(posedge SYS_CLK);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic cyc(input logic en, input logic trig, input logic pe,
                       input logic vld, input logic [WORD_W-1:0] data, input logic last);
        EN       = en;
        TRIG     = trig;
        CLK_PE   = pe;
        LD_VALID = vld;
        LD_DATA  = data;
        LD_LAST  = last;
        step();
        TRIG     = 1'b0;
        CLK_PE   = 1'b0;
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge SYS_CLK);
        SYS_RST_N = 1'b0;
        model_reset();
        #1;
        check("rst_gen", GEN_SIGNAL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_stale", STALE, 0);
        check("rst_ld_err", LD_ERR, 0);
        check("rst_ld_ready", LD_READY, 0);
        repeat (2) @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};

        model_reset();
        #2;
        check("por_gen", GEN_SIGNAL, 0);
        check("por_busy", BUSY, 0);
        check("por_stale", STALE, 0);
        check("por_ld_err", LD_ERR, 0);
        check("por_ld_ready", LD_READY, 0);
        repeat (2) @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;

        // Directed load + first bins of the reference image.
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].en, tbl[i].trig, tbl[i].pe, tbl[i].vld, tbl[i].data, tbl[i].last);
            check($sformatf("row%0d_gen", i), GEN_SIGNAL, tbl[i].gen);
            check($sformatf("row%0d_busy", i), BUSY, tbl[i].busy);
            check($sformatf("row%0d_stale", i), STALE, tbl[i].stale);
            check($sformatf("row%0d_ld_err", i), LD_ERR, tbl[i].err);
            check($sformatf("row%0d_ld_ready", i), LD_READY, tbl[i].rdy);
        end

        // Finish the sweep: bin 63 then DONE on the 64th strobe.
        for (int k = 0; k < 61; k++) cyc(1, 0, 1, 0, '0, 0);
        check("bin63_gen", GEN_SIGNAL, 2'b01);
        check("bin63_busy", BUSY, 1);
        cyc(1, 0, 1, 0, '0, 0);
        check("done_busy", BUSY, 0);
        check("done_gen", GEN_SIGNAL, 0);
        cyc(1, 0, 1, 0, '0, 0);
        check("done_hold_busy", BUSY, 0);

        // Replay without a new load.
        cyc(1, 1, 0, 0, '0, 0);
        check("replay_stale", STALE, 1);
        check("replay_bin0", GEN_SIGNAL, 2'b11);
        cyc(1, 0, 0, 0, '0, 0);
        check("replay_stale_once", STALE, 0);
        for (int k = 0; k < 64; k++) cyc(1, 0, 1, 0, '0, 0);
        check("replay_done_busy", BUSY, 0);

        // Retrigger mid-sweep, with TRIG and CLK_PE coincident.
        cyc(1, 1, 0, 0, '0, 0);
        for (int k = 0; k < 20; k++) cyc(1, 0, 1, 0, '0, 0);
        cyc(1, 1, 1, 0, '0, 0);
        check("retrig_busy", BUSY, 1);
        check("retrig_bin0", GEN_SIGNAL, 2'b11);

        // Early LD_LAST on word 2.
        cyc(1, 0, 0, 1, $urandom, 0);
        cyc(1, 0, 0, 1, $urandom, 1);
        check("early_last_err", LD_ERR, 1);
        check("early_last_ready", LD_READY, 1);
        cyc(1, 1, 0, 0, '0, 0);
        check("early_last_stale", STALE, 1);

        // TRIG coincident with the final load handshake.
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1, $urandom, 0);
        cyc(1, 1, 0, 1, $urandom, 1);
        check("coinc_stale", STALE, 1);
        check("coinc_ready", LD_READY, 0);
        cyc(1, 1, 0, 0, '0, 0);
        check("coinc_next_stale", STALE, 0);
        for (int k = 0; k < 10; k++) cyc(1, 0, 1, 0, '0, 0);

        // EN dropped mid-sweep and mid-load, then a clean reload.
        cyc(1, 0, 1, 1, $urandom, 0);
        cyc(1, 0, 1, 1, $urandom, 0);
        cyc(0, 0, 1, 0, '0, 0);
        check("en_low_gen", GEN_SIGNAL, 0);
        check("en_low_busy", BUSY, 0);
        cyc(0, 1, 0, 0, '0, 0);
        check("en_low_trig_stale", STALE, 0);
        for (int k = 0; k < IMG; k++) begin
            cyc(1, 0, 0, 1, $urandom, (k == IMG - 1) ? 1'b1 : 1'b0);
            check("reload_no_err", LD_ERR, 0);
        end
        check("reload_full", LD_READY, 0);
        cyc(1, 1, 0, 0, '0, 0);
        check("reload_swap", STALE, 0);

        // Reset in the middle of a sweep and a load.
        cyc(1, 0, 0, 1, $urandom, 0);
        cyc(1, 0, 1, 1, $urandom, 0);
        do_reset();
        cyc(1, 1, 0, 0, '0, 0);
        check("post_reset_stale", STALE, 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                    $urandom,
                    (m_cnt == IMG - 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
